decrement_then_stop_srst: RTL and testbench

Synchronous down-counter that loads a start value on reset and decrements by a programmable step each enabled cycle, saturating at a floor value and holding there. It is the descending counterpart of the increment-then-stop counter. Typical uses are drain/countdown sequencing in the MNIST datapath, such as remaining-pixel counts, layer tail flush and buffer unload. It reports completion with a level flag and a single-cycle pulse.

---
 rtl/decrement_then_stop_srst_if.sv | 24 ++
 rtl/decrement_then_stop_srst.sv | 89 ++++++++
 tb/tb_decrement_then_stop_srst.sv | 103 ++++++++++
 3 files changed

// File: rtl/decrement_then_stop_srst_if.sv
// Bus bundle for decrement_then_stop_srst: control/data inputs and count/status outputs.
// The master side drives the load values, step and enable; the slave is the counter.
interface decrement_then_stop_srst_if #(
  parameter int Bits = 8
);
  logic            en_i;
  logic [Bits-1:0] start_val_i;
  logic [Bits-1:0] end_val_i;
  logic [Bits-1:0] step_i;
  logic [Bits-1:0] count_o;
  logic [Bits-1:0] remaining_o;
  logic            done_o;
  logic            done_pulse_o;

  modport master (
    output en_i, start_val_i, end_val_i, step_i,
    input  count_o, remaining_o, done_o, done_pulse_o
  );

  modport slave (
    input  en_i, start_val_i, end_val_i, step_i,
    output count_o, remaining_o, done_o, done_pulse_o
  );
endinterface

// File: rtl/decrement_then_stop_srst.sv
// Saturating down-counter: loads start/floor on srst_i, steps down while en_i, holds at the floor.
// Optional simulation checks are compiled in with DECREMENT_THEN_STOP_ASSERT_EN.
module decrement_then_stop_srst #(
  parameter int Bits = 8
) (
  input logic                         clk_i,
  input logic                         srst_i,
  decrement_then_stop_srst_if.slave   bus
);

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t          r_state, w_state_next;
  logic [Bits-1:0] r_count, w_count_next;
  logic [Bits-1:0] r_end, w_end_next;
  logic [Bits-1:0] r_remaining, w_remaining_next;
  logic            r_done, w_done_next;
  logic            r_pulse, w_pulse_next;
  logic [Bits-1:0] w_diff;

  // Distance to the floor; never negative once a valid load has happened.
  assign w_diff = r_count - r_end;

  always_ff @(posedge clk_i) begin
    r_state     <= w_state_next;
    r_count     <= w_count_next;
    r_end       <= w_end_next;
    r_remaining <= w_remaining_next;
    r_done      <= w_done_next;
    r_pulse     <= w_pulse_next;
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_end_next       = r_end;
    w_remaining_next = r_remaining;
    w_done_next      = r_done;
    w_pulse_next     = 1'b0;

    if (srst_i) begin
      w_count_next     = bus.start_val_i;
      w_end_next       = bus.end_val_i;
      w_remaining_next = bus.start_val_i - bus.end_val_i;
      w_done_next      = (bus.start_val_i == bus.end_val_i);
      w_state_next     = (bus.start_val_i == bus.end_val_i) ? ST_DONE : ST_COUNT;
    end else if (bus.en_i) begin
      case (r_state)
        ST_COUNT: begin
          if (bus.step_i >= w_diff) begin
            w_count_next     = r_end;
            w_remaining_next = '0;
            w_done_next      = 1'b1;
            w_pulse_next     = 1'b1;
            w_state_next     = ST_DONE;
          end else begin
            w_count_next     = r_count - bus.step_i;
            w_remaining_next = w_diff - bus.step_i;
          end
        end
        default: begin
          w_state_next = ST_DONE;
        end
      endcase
    end
  end

  assign bus.count_o      = r_count;
  assign bus.remaining_o  = r_remaining;
  assign bus.done_o       = r_done;
  assign bus.done_pulse_o = r_pulse;

`ifdef DECREMENT_THEN_STOP_ASSERT_EN
  always @(posedge clk_i) begin
    if (srst_i) begin
      assert (bus.end_val_i <= bus.start_val_i)
        else $error("invalid load: end_val_i=%h > start_val_i=%h", bus.end_val_i, bus.start_val_i);
    end else if (bus.en_i) begin
      assert (r_count >= r_end)
        else $error("invariant breach: count=%h below end=%h", r_count, r_end);
    end
  end
`else
`endif

endmodule

// File: tb/tb_decrement_then_stop_srst.sv
// Directed-vector bench for decrement_then_stop_srst; one line per transaction.
module tb_decrement_then_stop_srst;

  logic clk_i = 1'b0;
  logic srst_i;
  int   checks = 0;
  int   failures = 0;

  decrement_then_stop_srst_if #(.Bits(8)) bus ();

  decrement_then_stop_srst #(.Bits(8)) dut (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs, clock once, then compare all outputs 1 time unit after the edge.
  task automatic cyc(input string tag, input logic rst, input logic en,
                     input int start_v, input int end_v, input int step,
                     input int ec, input int er, input int ed, input int ep);
    srst_i          = rst;
    bus.en_i        = en;
    bus.start_val_i = 8'(start_v);
    bus.end_val_i   = 8'(end_v);
    bus.step_i      = 8'(step);
    @(posedge clk_i);
    #1;
    $display("%s rst=%0b en=%0b step=%0d -> count=%0d rem=%0d done=%0b pulse=%0b",
             tag, rst, en, step, bus.count_o, bus.remaining_o, bus.done_o, bus.done_pulse_o);
    chk({tag, ".count"}, int'(bus.count_o), ec);
    chk({tag, ".rem"},   int'(bus.remaining_o), er);
    chk({tag, ".done"},  int'(bus.done_o), ed);
    chk({tag, ".pulse"}, int'(bus.done_pulse_o), ep);
  endtask

  int d1_c[10] = '{9, 8, 7, 6, 5, 4, 3, 3, 3, 3};
  int d1_p[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int d2_c[5]  = '{16, 12, 8, 5, 5};
  int d2_r[5]  = '{11, 7, 3, 0, 0};
  int d2_p[5]  = '{0, 0, 0, 1, 0};
  int d3_e[5]  = '{1, 0, 1, 0, 1};
  int d3_c[5]  = '{4, 4, 2, 2, 0};
  int d3_p[5]  = '{0, 0, 0, 0, 1};

  initial begin
    srst_i = 1'b0;
    bus.en_i = 1'b0;
    bus.start_val_i = '0;
    bus.end_val_i = '0;
    bus.step_i = '0;
    @(negedge clk_i);

    // Basic drain
    cyc("drain.load", 1, 0, 10, 3, 1, 10, 7, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("drain[%0d]", i), 0, 1, 10, 3, 1, d1_c[i], d1_c[i] - 3, (i >= 6) ? 1 : 0, d1_p[i]);

    // Saturating step
    cyc("sat.load", 1, 0, 20, 5, 4, 20, 15, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc($sformatf("sat[%0d]", i), 0, 1, 20, 5, 4, d2_c[i], d2_r[i], (i >= 3) ? 1 : 0, d2_p[i]);
    cyc("sat.idle", 0, 0, 20, 5, 4, 5, 0, 1, 0);

    // Enable gaps then zero step
    cyc("gap.load", 1, 0, 6, 0, 2, 6, 6, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc($sformatf("gap[%0d]", i), 0, logic'(d3_e[i]), 6, 0, 2, d3_c[i], d3_c[i], (i == 4) ? 1 : 0, d3_p[i]);
    cyc("gap.zero", 0, 1, 6, 0, 0, 0, 0, 1, 0);

    // Priority of load over enable, mid-count reload
    cyc("prio.load", 1, 0, 50, 10, 5, 50, 40, 0, 0);
    cyc("prio[0]", 0, 1, 50, 10, 5, 45, 35, 0, 0);
    cyc("prio[1]", 0, 1, 50, 10, 5, 40, 30, 0, 0);
    cyc("prio[2]", 0, 1, 50, 10, 5, 35, 25, 0, 0);
    cyc("prio.both", 1, 1, 40, 10, 5, 40, 30, 0, 0);
    cyc("prio.next", 0, 1, 40, 10, 5, 35, 25, 0, 0);

    // Zero-step while counting: no change, no done
    cyc("zstep", 0, 1, 40, 10, 0, 35, 25, 0, 0);

    // Degenerate load and latched end value
    cyc("degen.load", 1, 0, 7, 7, 1, 7, 0, 1, 0);
    cyc("degen.en", 0, 1, 7, 7, 1, 7, 0, 1, 0);
    cyc("latch.load", 1, 0, 9, 7, 1, 9, 2, 0, 0);
    cyc("latch[0]", 0, 1, 9, 0, 1, 8, 1, 0, 0);
    cyc("latch[1]", 0, 1, 9, 0, 1, 7, 0, 1, 1);
    cyc("latch[2]", 0, 1, 9, 0, 1, 7, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
